pll_clkgen_mc: RTL and testbench
================================

Name: pll_clkgen_mc

Overview:
- Multi-channel, runtime-reconfigurable clock-enable/divided-clock generator, driven from the Gowin_PLL output clock.
- Supervises PLL lock and holds all channels quiet until lock has been stable for a programmed settle time.
- Generates NUM_CH phase-aligned divided outputs and one-cycle enables, plus a lock-qualified downstream reset.
- Replaces fixed per-frequency PLL instances: one PLL feeds this block, and divide/duty/phase are changed live through a handshake.

Parameters:
- NUM_CH, 4, number of output channels (1..16)
- CNT_W, 16, width of divide/high/phase counters
- SETTLE_CYC, 1024, consecutive locked cycles required before RUN (>=1)
- DEF_DIV, 10, reset divide ratio of every channel (>=2)
- CH_W, max(1,clog2(NUM_CH)), derived; width of cfg_ch

Ports:
- clkin  in  1  PLL output clock; sole clock
- resetn  in  1  synchronous active-low reset
- pll_lock  in  1  PLL LOCK, asynchronous; 2-flop synchronised internally
- cfg_valid  in  1  reconfiguration request
- cfg_ready  out  1  block can accept a request
- cfg_ch  in  CH_W  target channel
- cfg_div  in  CNT_W  divide ratio N (period N clkin cycles)
- cfg_high  in  CNT_W  high-time H in cycles
- cfg_phase  in  CNT_W  counter start value applied on entry to RUN
- ch_out  out  NUM_CH  divided square outputs, registered
- ch_ce  out  NUM_CH  one-cycle enable per period, registered
- rst_out_n  out  1  downstream synchronous active-low reset
- locked  out  1  high while in RUN
- lock_lost_cnt  out  8  saturating count of lock losses from RUN

Behaviour:
- Reset (resetn=0 at an edge): state=WAIT_LOCK; ch_out=0, ch_ce=0, rst_out_n=0, locked=0, lock_lost_cnt=0, cfg_ready=1; sync flops=0.
- Reset (continued): every channel returns to N=DEF_DIV, H=DEF_DIV/2, phase=0, pending=0, cnt=0. resetn mid-operation overrides everything in the same edge.
- lock_s is pll_lock delayed by 2 flops.
- FSM WAIT_LOCK: settle_cnt=0; lock_s=1 -> SETTLE.
- FSM SETTLE: settle_cnt++; lock_s=0 -> WAIT_LOCK with no counter increment; settle_cnt==SETTLE_CYC-1 -> RUN, loading every enabled channel cnt with its phase.
- FSM RUN: lock_s=0 -> WAIT_LOCK and lock_lost_cnt++, saturating at 255.
- locked and rst_out_n are registered: 1 in the cycle after RUN is entered, 0 in the cycle after RUN is left. Outside RUN, ch_out=0 and ch_ce=0.
- Channel counter: cnt counts 0..N-1 and wraps to 0.
- Channel outputs: ch_ce<=(cnt==0); ch_out<=(cnt<H). Both have 1-cycle latency from cnt.
- Clamps applied at write: phase>=N -> 0; H>=N -> N-1; H=0 -> ch_out constant 0 while ch_ce still pulses.
- N<2: channel disabled, cnt held 0, ch_out=0, ch_ce=0.
- Handshake: a transfer occurs on cfg_valid&cfg_ready.
  - cfg_ch>=NUM_CH: transfer accepted and discarded; cfg_ready stays 1.
  - Otherwise the values go to that channel's shadow, pending=1, and cfg_ready=0 from the next cycle.
- Shadow apply: in RUN with the channel enabled, the shadow is applied at the cycle where cnt==N_old-1. The new period starts at cnt=0, with no runt or stretched pulse; phase is not applied live.
- Shadow apply otherwise (not RUN, or channel disabled): applied in the next cycle. A channel going disabled->enabled in RUN starts at cnt=phase.
- After apply: pending clears; cfg_ready=1 in the following cycle. Only one request is outstanding at a time.
- A lock loss with a pending update keeps the update, which is applied next cycle (not RUN).
- All arithmetic is unsigned CNT_W; there is no overflow because cnt<N<=2^CNT_W-1.

Decomposition:
- Package pll_clkgen_pkg: FSM state enum (WAIT_LOCK, SETTLE, RUN), lost-counter width 8, and the clamp rule as a function.
- Sub-module pll_clkgen_chan (one per channel, generate loop): counter, shadow/pending logic, clamp, and output flops.
- The top holds the lock synchroniser, FSM, settle counter and handshake.

Test Plan:
- Bench SETTLE_CYC=16, pll_lock=1 throughout, resetn released -> locked=1 and rst_out_n=1 exactly 19 cycles after the first released edge; ch0 ch_ce pulses one cycle later.
- Default DEF_DIV=10 -> every ch_out has period 10, 5 high/5 low; exactly one ch_ce per 10 cycles, coincident with ch_out rising.
- In RUN, write ch1 div=6 high=2 when cnt=3 -> cfg_ready falls; old 10-cycle period completes; then period 6 with 2 high; cfg_ready=1 one cycle after apply.
- ch2 phase=5, div=10, then re-lock -> ch2 ch_ce occurs 5 cycles after ch0 ch_ce, every period.
- pll_lock low for 1 cycle in RUN -> outputs 0 and locked=0 within 3 cycles; lock_lost_cnt=1; full 16-cycle re-settle before RUN. A 256th loss keeps the count at 255.
- Boundaries:
  - cfg_div=0 -> channel constant 0.
  - cfg_high=20 with div=8 -> high 7 cycles.
  - cfg_ch=7 with NUM_CH=4 -> ignored, cfg_ready stays 1.
  - resetn=0 mid-RUN -> all outputs at reset values next edge.

Source files
------------

// File: rtl/pll_clkgen_pkg.sv
// pll_clkgen_pkg: shared FSM type, loss-counter width and write-time clamp rules
package pll_clkgen_pkg;
    typedef enum logic [1:0] {WAIT_LOCK, SETTLE, RUN} state_t;
    localparam int LOST_W = 8;
    function automatic logic [31:0] clamp_high(input logic [31:0] n, input logic [31:0] h);
        return (h >= n) ? ((n == 32'd0) ? 32'd0 : n - 32'd1) : h;
    endfunction
    function automatic logic [31:0] clamp_phase(input logic [31:0] n, input logic [31:0] p);
        return (p >= n) ? 32'd0 : p;
    endfunction
endpackage

// File: rtl/pll_clkgen_chan.sv
// pll_clkgen_chan: one divided-clock channel with shadowed, glitch-free reconfiguration
module pll_clkgen_chan
    import pll_clkgen_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int DEF_DIV = 10
) (
    input  logic             clkin,
    input  logic             resetn,
    input  logic             run,
    input  logic             active,
    input  logic             wr,
    input  logic [CNT_W-1:0] div,
    input  logic [CNT_W-1:0] high,
    input  logic [CNT_W-1:0] phase,
    output logic             pending,
    output logic             ch_out,
    output logic             ch_ce
);
    logic [CNT_W-1:0] n, h, p, sn, sh, sp, cnt, cnt_nxt;
    logic en, wrap, apply;
    // Live updates wait for the period boundary; otherwise the shadow lands at once
    always_comb begin
        en      = n >= CNT_W'(2);
        wrap    = cnt == n - CNT_W'(1);
        apply   = pending && ((run && en) ? (active && wrap) : 1'b1);
        cnt_nxt = apply ? ((run && en) ? '0 : (sn >= CNT_W'(2)) ? sp : '0)
                : (run && !active) ? (en ? p : '0)
                : (active && en) ? (wrap ? '0 : cnt + CNT_W'(1))
                : cnt;
    end
    // Shadow capture, configuration apply, counter and registered outputs
    always_ff @(posedge clkin) begin
        if (!resetn) begin
            n       <= CNT_W'(DEF_DIV);
            h       <= CNT_W'(DEF_DIV / 2);
            p       <= '0;
            sn      <= '0;
            sh      <= '0;
            sp      <= '0;
            pending <= 1'b0;
            cnt     <= '0;
            ch_out  <= 1'b0;
            ch_ce   <= 1'b0;
        end else begin
            if (wr) begin
                sn <= div;
                sh <= CNT_W'(clamp_high(32'(div), 32'(high)));
                sp <= CNT_W'(clamp_phase(32'(div), 32'(phase)));
            end
            if (apply) begin
                n <= sn;
                h <= sh;
                p <= sp;
            end
            pending <= wr || (pending && !apply);
            cnt     <= cnt_nxt;
            ch_ce   <= active && en && cnt == '0;
            ch_out  <= active && en && cnt < h;
        end
    end
endmodule

// File: rtl/pll_clkgen_mc.sv
// pll_clkgen_mc: lock-supervised multi-channel divided clock / enable generator
module pll_clkgen_mc
    import pll_clkgen_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int CNT_W      = 16,
    parameter int SETTLE_CYC = 1024,
    parameter int DEF_DIV    = 10,
    parameter int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clkin,
    input  logic              resetn,
    input  logic              pll_lock,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic [CNT_W-1:0]  cfg_high,
    input  logic [CNT_W-1:0]  cfg_phase,
    output logic [NUM_CH-1:0] ch_out,
    output logic [NUM_CH-1:0] ch_ce,
    output logic              rst_out_n,
    output logic              locked,
    output logic [LOST_W-1:0] lock_lost_cnt
);
    localparam int SW = $clog2(SETTLE_CYC) + 1;
    state_t state, state_nxt;
    logic sync1, lock_s, settle_done, lost_inc, run, active;
    logic [SW-1:0] settle_cnt;
    logic [NUM_CH-1:0] pending, wr;
    assign run       = state == RUN;
    assign active    = run && locked;
    assign cfg_ready = ~|pending;
    assign rst_out_n = locked;
    // Next state: any loss of lock returns to WAIT_LOCK, otherwise advance when settled
    always_comb begin
        settle_done = settle_cnt == SW'(SETTLE_CYC - 1);
        lost_inc    = run && !lock_s;
        state_nxt   = !lock_s ? WAIT_LOCK
                    : state == WAIT_LOCK ? SETTLE
                    : (state == SETTLE && !settle_done) ? SETTLE
                    : RUN;
    end
    // Lock synchroniser, state register, settle timer, lock status and loss counter
    always_ff @(posedge clkin) begin
        if (!resetn) begin
            sync1         <= 1'b0;
            lock_s        <= 1'b0;
            state         <= WAIT_LOCK;
            settle_cnt    <= '0;
            locked        <= 1'b0;
            lock_lost_cnt <= '0;
        end else begin
            sync1      <= pll_lock;
            lock_s     <= sync1;
            state      <= state_nxt;
            settle_cnt <= (state == SETTLE && lock_s) ? settle_cnt + SW'(1) : '0;
            locked     <= run;
            if (lost_inc && lock_lost_cnt != '1) lock_lost_cnt <= lock_lost_cnt + LOST_W'(1);
        end
    end
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign wr[g] = cfg_valid && cfg_ready && cfg_ch == CH_W'(g);
        pll_clkgen_chan #(.CNT_W(CNT_W), .DEF_DIV(DEF_DIV)) u_chan (
            .clkin   (clkin),
            .resetn  (resetn),
            .run     (run),
            .active  (active),
            .wr      (wr[g]),
            .div     (cfg_div),
            .high    (cfg_high),
            .phase   (cfg_phase),
            .pending (pending[g]),
            .ch_out  (ch_out[g]),
            .ch_ce   (ch_ce[g])
        );
    end
endmodule

// File: tb/tb_pll_clkgen_mc.sv
// tb_pll_clkgen_mc: directed scoreboard bench for pll_clkgen_mc
module tb_pll_clkgen_mc;
    logic clk = 1'b0, resetn = 1'b0, pll_lock = 1'b1;
    logic cfg_valid = 1'b0, cfg_ready;
    logic [1:0] cfg_ch = '0;
    logic [15:0] cfg_div = '0, cfg_high = '0, cfg_phase = '0;
    logic [3:0] ch_out, ch_ce;
    logic rst_out_n, locked;
    logic [7:0] lock_lost_cnt;
    logic odd_valid = 1'b0, odd_ready, odd_rst_n, odd_locked;
    logic [1:0] odd_ch = '0;
    logic [2:0] odd_out, odd_ce;
    logic [7:0] odd_lost;
    typedef struct { string tag; logic [31:0] val; } exp_t;
    exp_t sb[$];
    int vectors = 0, miscompares = 0, e = 0, p0 = 0;

    always #5 clk = ~clk;

    pll_clkgen_mc #(.NUM_CH(4), .CNT_W(16), .SETTLE_CYC(16), .DEF_DIV(10)) dut (
        .clkin(clk), .resetn(resetn), .pll_lock(pll_lock),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
        .cfg_div(cfg_div), .cfg_high(cfg_high), .cfg_phase(cfg_phase),
        .ch_out(ch_out), .ch_ce(ch_ce), .rst_out_n(rst_out_n),
        .locked(locked), .lock_lost_cnt(lock_lost_cnt)
    );

    pll_clkgen_mc #(.NUM_CH(3), .CNT_W(16), .SETTLE_CYC(16), .DEF_DIV(10)) odd (
        .clkin(clk), .resetn(resetn), .pll_lock(pll_lock),
        .cfg_valid(odd_valid), .cfg_ready(odd_ready), .cfg_ch(odd_ch),
        .cfg_div(16'd2), .cfg_high(16'd1), .cfg_phase(16'd0),
        .ch_out(odd_out), .ch_ce(odd_ce), .rst_out_n(odd_rst_n),
        .locked(odd_locked), .lock_lost_cnt(odd_lost)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        e++;
    endtask

    task automatic push(input string tag, input logic [31:0] val);
        exp_t x;
        x.tag = tag;
        x.val = val;
        sb.push_back(x);
    endtask

    task automatic chk(input logic [31:0] obs);
        exp_t x;
        x.tag = "scoreboard_underflow";
        x.val = 'x;
        if (sb.size() > 0) x = sb.pop_front();
        vectors++;
        assert (obs === x.val) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", x.tag, obs, x.val);
        end
    endtask

    task automatic send(input logic [1:0] ch, input logic [15:0] dv, input logic [15:0] hi, input logic [15:0] ph);
        cfg_valid = 1'b1; cfg_ch = ch; cfg_div = dv; cfg_high = hi; cfg_phase = ph;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        for (int i = 0; i < 24 && !cfg_ready; i++) tick();
        push(tag, 32'd1);
        chk(32'(cfg_ready));
    endtask

    task automatic wait_locked(input logic v, input string tag);
        for (int i = 0; i < 40 && locked !== v; i++) tick();
        push(tag, 32'(v));
        chk(32'(locked));
    endtask

    task automatic reset_state(input string tag);
        push({tag, "_outs"}, 32'd0);     chk(32'({ch_out, ch_ce}));
        push({tag, "_rst_out_n"}, 32'd0); chk(32'(rst_out_n));
        push({tag, "_locked"}, 32'd0);    chk(32'(locked));
        push({tag, "_lost"}, 32'd0);      chk(32'(lock_lost_cnt));
        push({tag, "_ready"}, 32'd1);     chk(32'(cfg_ready));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        @(negedge clk);
        tick(); tick(); tick();
        reset_state("reset");
        // release: edge 0 is the first edge with resetn high
        resetn = 1'b1;
        e = -1;
        while (e < 18) tick();
        push("locked_pre", 32'd0); chk(32'(locked));
        tick();
        push("locked_at19", 32'd1); chk(32'(locked));
        push("rst_out_at19", 32'd1); chk(32'(rst_out_n));
        push("ce_at19", 32'd0); chk(32'(ch_ce));
        tick();
        push("first_ce", 32'h0FF); chk(32'({ch_out, ch_ce}));
        // default divide 10, 5 high
        for (int t = 21; t < 40; t++) begin
            int k;
            k = (t - 20) % 10;
            push("default_period", 32'({(k < 5) ? 4'hF : 4'h0, (k == 0) ? 4'hF : 4'h0}));
        end
        for (int t = 21; t < 40; t++) begin tick(); chk(32'({ch_out, ch_ce})); end
        // ch1 rewrite while its counter is 3
        while (e < 42) tick();
        send(2'd1, 16'd6, 16'd2, 16'd0);
        push("ready_low", 32'd0); chk(32'(cfg_ready));
        for (int t = 44; t < 62; t++) begin
            int k;
            logic o, c;
            if (t < 50) begin k = (t - 20) % 10; o = k < 5; end
            else begin k = (t - 50) % 6; o = k < 2; end
            c = k == 0;
            push("ch1_retime", 32'({t >= 49, o, c}));
        end
        for (int t = 44; t < 62; t++) begin tick(); chk(32'({cfg_ready, ch_out[1], ch_ce[1]})); end
        // ch2 phase 5, then a one-cycle lock drop to re-enter RUN
        send(2'd2, 16'd10, 16'd5, 16'd5);
        wait_ready("ch2_ready");
        pll_lock = 1'b0;
        tick();
        p0 = e;
        pll_lock = 1'b1;
        tick(); tick();
        push("locked_hold", 32'd1); chk(32'(locked));
        tick();
        push("locked_drop", 32'd0); chk(32'(locked));
        push("outs_drop", 32'd0); chk(32'({ch_out, ch_ce}));
        push("rst_drop", 32'd0); chk(32'(rst_out_n));
        push("lost_one", 32'd1); chk(32'(lock_lost_cnt));
        while (e < p0 + 19) tick();
        push("resettle_full", 32'd0); chk(32'(locked));
        tick();
        push("relocked", 32'd1); chk(32'(locked));
        for (int t = 0; t < 20; t++)
            push("phase_ce", 32'({t % 10 == 0, t % 10 == 5, t % 6 == 0, t % 10 == 0}));
        for (int t = 0; t < 20; t++) begin tick(); chk(32'(ch_ce)); end
        // ch3 divide 0 -> silent
        send(2'd3, 16'd0, 16'd0, 16'd0);
        wait_ready("ch3_off_ready");
        for (int t = 0; t < 12; t++) push("ch3_off", 32'd0);
        for (int t = 0; t < 12; t++) begin tick(); chk(32'({ch_out[3], ch_ce[3]})); end
        // ch3 divide 8 with oversize high -> 7 high
        send(2'd3, 16'd8, 16'd20, 16'd0);
        wait_ready("ch3_on_ready");
        for (int t = 0; t < 16; t++) push("ch3_clamp", 32'({t % 8 < 7, t % 8 == 0}));
        for (int t = 0; t < 16; t++) begin tick(); chk(32'({ch_out[3], ch_ce[3]})); end
        // out-of-range channel on the 3-channel instance is swallowed
        odd_valid = 1'b1; odd_ch = 2'd3;
        tick();
        odd_valid = 1'b0;
        for (int t = 0; t < 3; t++) push("odd_ready", 32'd1);
        for (int t = 0; t < 3; t++) begin chk(32'(odd_ready)); tick(); end
        // drive the loss counter to saturation
        for (int i = 2; i <= 256; i++) begin
            wait_locked(1'b1, "loop_relock");
            pll_lock = 1'b0;
            tick();
            pll_lock = 1'b1;
            wait_locked(1'b0, "loop_loss");
            if (i == 255) begin push("lost_255", 32'd255); chk(32'(lock_lost_cnt)); end
        end
        push("lost_sat", 32'd255); chk(32'(lock_lost_cnt));
        // reset in the middle of RUN
        wait_locked(1'b1, "pre_reset_lock");
        tick(); tick();
        resetn = 1'b0;
        tick();
        reset_state("midrun_reset");
        resetn = 1'b1;
        wait_locked(1'b1, "post_reset_lock");
        for (int t = 0; t < 10; t++) push("post_reset_ce", (t == 0) ? 32'hF : 32'h0);
        for (int t = 0; t < 10; t++) begin tick(); chk(32'(ch_ce)); end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
